// File: rtl/store_commit_unit.sv
// store_commit_unit
//   Drains retired stores from the store queue to memory, strictly in program
//   order, with at most one write in flight at a time.
//
// Ports
//   clk, reset_n       clock; synchronous active-low reset
//   stq_valid          per-entry valid
//   stq_retired        per-entry "committed by the ROB"
//   stq_address/data   per-entry address/data, flat vectors, XLEN bits per entry
//   stq_width          per-entry size (0 byte, 1 half, 2 word), 2 bits per entry
//   mem_req_*          write request channel (valid/ready, addr, wdata, width)
//   mem_resp_valid     one-cycle write-complete acknowledge
//   stq_head           index of the oldest store not yet drained
//   stq_commit(_index) one-cycle pulse when the head store completes
//   commit_count       number of stores drained since reset (wraps)
//   busy               unit is not idle
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for the head entry to be valid and retired
// REQ      | presenting the captured store to memory until accepted
// WAIT_ACK | request accepted, waiting for the write-complete acknowledge
module store_commit_unit #(
  parameter int XLEN     = 32,
  parameter int STQ_SIZE = 32,
  localparam int IW      = $clog2(STQ_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [STQ_SIZE-1:0]      stq_valid,
  input  logic [STQ_SIZE-1:0]      stq_retired,
  input  logic [STQ_SIZE*XLEN-1:0] stq_address,
  input  logic [STQ_SIZE*XLEN-1:0] stq_data,
  input  logic [STQ_SIZE*2-1:0]    stq_width,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [1:0]               mem_width,
  input  logic                     mem_resp_valid,
  output logic [IW-1:0]            stq_head,
  output logic                     stq_commit,
  output logic [IW-1:0]            stq_commit_index,
  output logic [31:0]              commit_count,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   head_q, head_d;
  logic [31:0]     count_q, count_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [1:0]      width_q, width_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      width_q <= width_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    count_d       = count_q;
    addr_d        = addr_q;
    data_d        = data_q;
    width_d       = width_q;
    mem_req_valid = 1'b0;
    stq_commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only the head may drain; a stalled head blocks all younger entries.
        if (stq_valid[head_q] && stq_retired[head_q]) begin
          addr_d  = stq_address[head_q*XLEN +: XLEN];
          data_d  = stq_data[head_q*XLEN +: XLEN];
          width_d = stq_width[head_q*2 +: 2];
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (mem_resp_valid) begin
          stq_commit = 1'b1;
          // STQ_SIZE is a power of two, so the head wraps naturally.
          head_d     = head_q + IW'(1);
          count_d    = count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr         = addr_q;
  assign mem_wdata        = data_q;
  assign mem_width        = width_q;
  assign stq_head         = head_q;
  assign stq_commit_index = head_q;
  assign commit_count     = count_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: doc/store_commit_unit.md
STORE_COMMIT_UNIT -- requirements
Module: store_commit_unit

Interface
REQ-001 Parameter XLEN, default 32: address/data width.
REQ-002 Parameter STQ_SIZE, default 32 (power of two): store queue depth; IW = $clog2(STQ_SIZE).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 stq_valid  input  STQ_SIZE  per-entry valid.
REQ-006 stq_retired  input  STQ_SIZE  per-entry flag: ROB has committed this store.
REQ-007 stq_address  input  STQ_SIZE x XLEN  per-entry store address.
REQ-008 stq_data  input  STQ_SIZE x XLEN  per-entry store data.
REQ-009 stq_width  input  STQ_SIZE x 2  per-entry size: 0 byte, 1 half, 2 word.
REQ-010 mem_req_valid  output  1  write request valid.
REQ-011 mem_req_ready  input  1  memory accepts request this cycle.
REQ-012 mem_addr  output  XLEN  write address.
REQ-013 mem_wdata  output  XLEN  write data.
REQ-014 mem_width  output  2  write size, stq_width encoding.
REQ-015 mem_resp_valid  input  1  one-cycle write-complete acknowledge.
REQ-016 stq_head  output  IW  index of oldest store not yet drained.
REQ-017 stq_commit  output  1  one-cycle pulse: store at stq_commit_index written to memory.
REQ-018 stq_commit_index  output  IW  index of store committing this cycle.
REQ-019 commit_count  output  32  total stores drained since reset.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM SHALL have states IDLE, REQ, WAIT_ACK.
REQ-022 IDLE: when stq_valid[stq_head] && stq_retired[stq_head], register that entry's address, data, width and go to REQ next cycle; otherwise remain in IDLE.
REQ-023 REQ: mem_req_valid SHALL be 1 with registered addr/wdata/width stable until handshake; on mem_req_valid && mem_req_ready go to WAIT_ACK.
REQ-024 mem_req_valid SHALL be 0 in IDLE and WAIT_ACK; it is never withdrawn before ready.
REQ-025 WAIT_ACK: on mem_resp_valid, stq_commit SHALL be 1 and stq_commit_index SHALL equal stq_head for exactly that cycle (combinational from state); next cycle stq_head increments, commit_count increments, state returns to IDLE.
REQ-026 mem_resp_valid in IDLE or REQ SHALL be ignored (no state change, no pulse).
REQ-027 stq_head SHALL wrap from STQ_SIZE-1 to 0; commit_count SHALL wrap modulo 2^32.
REQ-028 Changes to stq_* inputs of the head entry after capture SHALL NOT affect the in-flight request.
REQ-029 Minimum drain latency: 1 cycle IDLE->REQ, >=1 cycle REQ, >=1 cycle WAIT_ACK; at most one store in flight; back-to-back stores SHALL be separated by at least one IDLE cycle.
REQ-030 stq_commit SHALL be 0 whenever state is not WAIT_ACK or mem_resp_valid is 0; stq_commit_index SHALL equal stq_head at all times.
REQ-031 A non-retired or invalid head entry SHALL stall the unit in IDLE indefinitely; younger retired entries SHALL NOT be drained out of order.

Reset
REQ-032 While reset_n=0 at a rising edge: state<=IDLE, stq_head<=0, commit_count<=0; mem_req_valid, stq_commit, busy read 0.
REQ-033 Reset asserted in REQ or WAIT_ACK SHALL abandon the in-flight store without a stq_commit pulse; a later mem_resp_valid SHALL be ignored.
REQ-034 mem_addr, mem_wdata, mem_width SHALL reset to 0.

Verification
REQ-035 Single store: entry 0 valid+retired, addr 0x100, data 0xDEADBEEF, width 2, ready=1, resp 2 cycles after accept -> one request 0x100/0xDEADBEEF, one stq_commit pulse with index 0, stq_head=1, commit_count=1.
REQ-036 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid held high with constant addr/data for 5 cycles, accepted on cycle 6, exactly one request.
REQ-037 Wrap: STQ_SIZE=4, head=3, entries 3 and 0 retired -> commits index 3 then 0, stq_head ends at 1, in order.
REQ-038 Ordering stall: entry 1 retired, head entry 0 valid but not retired for 10 cycles -> no request, busy=0; after entry 0 retires, commits 0 then 1.
REQ-039 Reset mid-flight: reset_n=0 in WAIT_ACK, then resp arrives -> no stq_commit, stq_head=0, commit_count=0.
REQ-040 Spurious ack: mem_resp_valid=1 in IDLE with no retired stores -> no pulse, stq_head and commit_count unchanged.
